keystream_sequencer: RTL and testbench

//  Byte-level controller for the 16-bit LFSR stream cipher used on the keyboard data path.

---
 rtl/keystream_sequencer.sv | 136 +++++++++++++
 tb/tb_keystream_sequencer.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keystream_sequencer.sv
// Byte-level controller for the 16-bit LFSR keystream cipher: steps the LFSR 8 times per byte, LSB first.
// Optional feature: define KEY_RESEED_EN to reload the LFSR from seed_reg every REKEY_BYTES delivered bytes.
module keystream_sequencer #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
    parameter int          CNT_W        = 16
`ifdef KEY_RESEED_EN
    ,
    parameter int          REKEY_BYTES  = 256
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    input  logic             seed_load,
    input  logic [0:15]      seed,
    output logic             busy,
    output logic             seed_err,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [0:15]      lfsr_q, lfsr_d;
    logic [0:15]      seed_reg_q, seed_reg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             seed_err_q, seed_err_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;

    logic             fb;
    logic [0:15]      lfsr_step;
    logic [0:15]      seed_safe;
    logic [CNT_W-1:0] byte_count_inc;

    // Index 15 is the bit shifted out; the new feedback bit enters at index 0.
    assign fb             = lfsr_q[10] ^ lfsr_q[12] ^ lfsr_q[13] ^ lfsr_q[15];
    assign lfsr_step      = {fb, lfsr_q[0:14]};
    assign seed_safe      = (seed == 16'h0000) ? SEED_DEFAULT : seed;
    assign byte_count_inc = byte_count_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        seed_reg_d   = seed_reg_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        out_data_d   = out_data_q;
        seed_err_d   = seed_err_q;
        byte_count_d = byte_count_q;

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    seed_reg_d   = seed_safe;
                    lfsr_d       = seed_safe;
                    byte_count_d = '0;
                    seed_err_d   = 1'b0;
                end else if (in_valid) begin
                    shift_d   = in_data;
                    bit_cnt_d = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                out_data_d[bit_cnt_q] = shift_q[bit_cnt_q] ^ lfsr_q[15];
                lfsr_d                = lfsr_step;
                bit_cnt_d             = bit_cnt_q + 3'd1;
                if (seed_load) begin
                    seed_err_d = 1'b1;
                end
                if (bit_cnt_q == 3'd7) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (seed_load) begin
                    seed_err_d = 1'b1;
                end
                if (out_ready) begin
                    byte_count_d = byte_count_inc;
                    state_d      = IDLE;
`ifdef KEY_RESEED_EN
                    // Restart the keystream on the same edge the count lands on a rekey boundary.
                    if ((byte_count_inc % CNT_W'(REKEY_BYTES)) == '0) begin
                        lfsr_d = seed_reg_q;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED_DEFAULT;
            seed_reg_q   <= SEED_DEFAULT;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            out_data_q   <= 8'h00;
            seed_err_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            seed_reg_q   <= seed_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            seed_err_q   <= seed_err_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign out_data   = out_data_q;
    assign seed_err   = seed_err_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_keystream_sequencer.sv
// Directed bench for keystream_sequencer; keystream bytes from seed ACE1 are E1, AC, 22, 47, 37.
// An encrypt/decrypt pair of instances is also run over random bytes.
module tb_keystream_sequencer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        seed_load;
    logic [0:15] seed;
    logic        busy;
    logic        seed_err;
    logic [15:0] byte_count;

    logic        enc_in_valid, enc_in_ready, enc_out_valid, dec_in_ready;
    logic [7:0]  enc_in_data, enc_out_data, dec_out_data;
    logic        dec_out_valid, dec_out_ready, rt_seed_load;
    logic [0:15] rt_seed;
    logic        enc_busy, enc_seed_err, dec_busy, dec_seed_err;
    logic [15:0] enc_count, dec_count;

    int checks;
    int failures;
    logic [7:0] rx_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef KEY_RESEED_EN
    keystream_sequencer #(.REKEY_BYTES(4)) dut (
`else
    keystream_sequencer dut (
`endif
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .seed_load(seed_load), .seed(seed),
        .busy(busy), .seed_err(seed_err), .byte_count(byte_count)
    );

    keystream_sequencer u_enc (
        .clock(clock), .reset(reset),
        .in_valid(enc_in_valid), .in_ready(enc_in_ready), .in_data(enc_in_data),
        .out_valid(enc_out_valid), .out_ready(dec_in_ready), .out_data(enc_out_data),
        .seed_load(rt_seed_load), .seed(rt_seed),
        .busy(enc_busy), .seed_err(enc_seed_err), .byte_count(enc_count)
    );

    keystream_sequencer u_dec (
        .clock(clock), .reset(reset),
        .in_valid(enc_out_valid), .in_ready(dec_in_ready), .in_data(enc_out_data),
        .out_valid(dec_out_valid), .out_ready(dec_out_ready), .out_data(dec_out_data),
        .seed_load(rt_seed_load), .seed(rt_seed),
        .busy(dec_busy), .seed_err(dec_seed_err), .byte_count(dec_count)
    );

    // Each decrypted byte is held for exactly one cycle while dec_out_ready is high.
    always @(negedge clock) begin
        if (!reset && dec_out_valid && dec_out_ready) begin
            rx_q.push_back(dec_out_data);
        end
    end

    task automatic apply_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        seed_load = 1'b0;
        seed      = 16'h0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Sends one byte with out_ready high; lat counts edges from driving in_valid to out_valid seen.
    task automatic send_byte(input logic [7:0] d, output logic [7:0] q, output int lat);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        q = out_data;
        checks++;
        if (!out_valid) begin
            failures++;
            $display("[TB] FAIL send_byte_timeout got out_valid=%b exp=1", out_valid);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, seed_err} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=1000", {in_ready, out_valid, busy, seed_err});
        end
        checks++;
        if (out_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_out_data got=%h exp=00", out_data);
        end
        checks++;
        if (byte_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_byte_count got=%0d exp=0", byte_count);
        end
    endtask

    task automatic test_basic_latency();
        logic [7:0] q;
        int lat;
        apply_reset();
        send_byte(8'h00, q, lat);
        checks++;
        if (q !== 8'hE1) begin
            failures++;
            $display("[TB] FAIL basic_data got=%h exp=E1", q);
        end
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d exp=9", lat);
        end
        checks++;
        if (byte_count !== 16'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_handshake got count=%0d valid=%b exp count=1 valid=0", byte_count, out_valid);
        end
    endtask

    task automatic test_inverse();
        logic [7:0] q;
        int lat;
        apply_reset();
        send_byte(8'hE1, q, lat);
        checks++;
        if (q !== 8'h00) begin
            failures++;
            $display("[TB] FAIL inverse_data got=%h exp=00", q);
        end
    endtask

    task automatic test_seed_load();
        logic [7:0] q;
        int lat;
        apply_reset();
        send_byte(8'h00, q, lat);
        seed_load = 1'b1;
        seed      = 16'h0000;
        @(posedge clock);
        #1;
        seed_load = 1'b0;
        checks++;
        if (byte_count !== 16'd0 || seed_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_seed_state got count=%0d err=%b busy=%b exp 0 0 0", byte_count, seed_err, busy);
        end
        send_byte(8'h00, q, lat);
        checks++;
        if (q !== 8'hE1) begin
            failures++;
            $display("[TB] FAIL zero_seed_data got=%h exp=E1", q);
        end
        seed_load = 1'b1;
        seed      = 16'h1234;
        @(posedge clock);
        #1;
        seed_load = 1'b0;
        send_byte(8'h00, q, lat);
        checks++;
        if (q !== 8'h34) begin
            failures++;
            $display("[TB] FAIL custom_seed_data got=%h exp=34", q);
        end
    endtask

    task automatic test_seed_busy();
        logic [7:0] q;
        int lat;
        int n;
        apply_reset();
        in_data  = 8'h00;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        seed_load = 1'b1;
        seed      = 16'h1234;
        @(posedge clock);
        #1;
        seed_load = 1'b0;
        checks++;
        if (seed_err !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_seed_err got err=%b busy=%b exp 1 1", seed_err, busy);
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hE1) begin
            failures++;
            $display("[TB] FAIL busy_seed_data got valid=%b data=%h exp 1 E1", out_valid, out_data);
        end
        @(posedge clock);
        #1;
        seed_load = 1'b1;
        seed      = 16'h5678;
        @(posedge clock);
        #1;
        seed_load = 1'b0;
        checks++;
        if (seed_err !== 1'b0 || byte_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL idle_seed_clear got err=%b count=%0d exp 0 0", seed_err, byte_count);
        end
        send_byte(8'h00, q, lat);
        checks++;
        if (q !== 8'h78) begin
            failures++;
            $display("[TB] FAIL idle_seed_data got=%h exp=78", q);
        end
    endtask

    task automatic test_hold_stall();
        logic [7:0] q;
        int lat;
        int n;
        int bad;
        apply_reset();
        out_ready = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid !== 1'b1 || out_data !== 8'hE1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL hold_stable got bad_cycles=%0d exp=0 (valid=%b data=%h)", bad, out_valid, out_data);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || byte_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL hold_release got valid=%b count=%0d exp 0 1", out_valid, byte_count);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (byte_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL hold_single_handshake got count=%0d exp=1", byte_count);
        end
        send_byte(8'h00, q, lat);
        checks++;
        if (q !== 8'hAC) begin
            failures++;
            $display("[TB] FAIL hold_lfsr_frozen got=%h exp=AC", q);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] q;
        int lat;
        int seen;
        apply_reset();
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midreset_state got busy=%b ready=%b data=%h exp 0 1 00", busy, in_ready, out_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen  = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || byte_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midreset_no_output got valid_cycles=%0d count=%0d exp 0 0", seen, byte_count);
        end
        send_byte(8'h00, q, lat);
        checks++;
        if (q !== 8'hE1) begin
            failures++;
            $display("[TB] FAIL midreset_restart got=%h exp=E1", q);
        end
    endtask

    task automatic test_back_to_back();
        int nseen;
        int t0;
        int t1;
        logic [7:0] d0;
        logic [7:0] d1;
        apply_reset();
        nseen    = 0;
        t0       = -1;
        t1       = -1;
        d0       = 8'h00;
        d1       = 8'h00;
        in_data  = 8'h00;
        in_valid = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                if (nseen == 0) begin
                    t0 = c;
                    d0 = out_data;
                end else if (nseen == 1) begin
                    t1 = c;
                    d1 = out_data;
                end
                nseen++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nseen !== 2 || t0 !== 9 || t1 !== 19) begin
            failures++;
            $display("[TB] FAIL b2b_timing got n=%0d t0=%0d t1=%0d exp 2 9 19", nseen, t0, t1);
        end
        checks++;
        if (d0 !== 8'hE1 || d1 !== 8'hAC) begin
            failures++;
            $display("[TB] FAIL b2b_data got %h %h exp E1 AC", d0, d1);
        end
        repeat (12) @(posedge clock);
        #1;
    endtask

    task automatic test_rekey();
        logic [7:0] b[8];
        int lat;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h00, b[i], lat);
        end
        checks++;
        if ({b[0], b[1], b[2], b[3]} !== 32'hE1AC2247) begin
            failures++;
            $display("[TB] FAIL rekey_first4 got %h %h %h %h exp E1 AC 22 47", b[0], b[1], b[2], b[3]);
        end
`ifdef KEY_RESEED_EN
        checks++;
        if (b[4] !== 8'hE1 || b[5] !== 8'hAC) begin
            failures++;
            $display("[TB] FAIL rekey_restart got %h %h exp E1 AC", b[4], b[5]);
        end
`else
        checks++;
        if (b[4] !== 8'h37) begin
            failures++;
            $display("[TB] FAIL rekey_continuous got=%h exp=37", b[4]);
        end
`endif
        checks++;
        if (byte_count !== 16'd8) begin
            failures++;
            $display("[TB] FAIL rekey_count got=%0d exp=8", byte_count);
        end
    endtask

    task automatic test_roundtrip();
        logic [7:0] sent[$];
        int n;
        int bad;
        logic [7:0] d;
        apply_reset();
        rx_q.delete();
        for (int i = 0; i < 1000; i++) begin
            d = 8'($urandom_range(0, 255));
            sent.push_back(d);
            enc_in_data  = d;
            enc_in_valid = 1'b1;
            n = 0;
            while (!enc_in_ready && n < 100) begin
                @(posedge clock);
                #1;
                n++;
            end
            @(posedge clock);
            #1;
            enc_in_valid = 1'b0;
        end
        n = 0;
        while (rx_q.size() < 1000 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (rx_q.size() !== 1000) begin
            failures++;
            $display("[TB] FAIL roundtrip_count got=%0d exp=1000", rx_q.size());
        end
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 1000; i++) begin
            if (rx_q[i] !== sent[i]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL roundtrip_data got mismatches=%0d exp=0", bad);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_data       = 8'h00;
        out_ready     = 1'b0;
        seed_load     = 1'b0;
        seed          = 16'h0000;
        enc_in_valid  = 1'b0;
        enc_in_data   = 8'h00;
        dec_out_ready = 1'b1;
        rt_seed_load  = 1'b0;
        rt_seed       = 16'h0000;

        test_reset();
        test_basic_latency();
        test_inverse();
        test_seed_load();
        test_seed_busy();
        test_hold_stall();
        test_reset_mid_byte();
        test_back_to_back();
        test_rekey();
        test_roundtrip();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
